// File: rtl/vote_display_ctrl_if.sv
// Bus bundle for vote_display_ctrl: voting/display controls in, display out.
// master = driver of the controls (upstream logic), slave = the controller.
interface vote_display_ctrl_if #(
  parameter int NUM_CAND = 4,
  parameter int CNT_W    = 8
);
  localparam int IDX_W = $clog2(NUM_CAND);

  logic                      mode;
  logic                      valid_vote_casted;
  logic [NUM_CAND*CNT_W-1:0] cand_votes;
  logic [NUM_CAND-1:0]       cand_button;
  logic [CNT_W-1:0]          LEDs;
  logic [IDX_W-1:0]          sel_idx;
  logic                      sel_valid;

  modport master (
    output mode, valid_vote_casted, cand_votes, cand_button,
    input  LEDs, sel_idx, sel_valid
  );

  modport slave (
    input  mode, valid_vote_casted, cand_votes, cand_button,
    output LEDs, sel_idx, sel_valid
  );
endinterface

// File: rtl/vote_display_ctrl.sv
// Voting-machine display controller.
// Voting mode: a registered vote blinks the LEDs all-ones for BLINK_CYCLES
// clocks (retriggerable). Result mode: a candidate button latches which
// candidate's count is shown, tracked live every cycle.
// Optional macro VOTE_LEADER_DISPLAY_EN: with no candidate selected in result
// mode, the current leader (max count, lowest index on ties) is shown instead
// of a blank display.
module vote_display_ctrl #(
  parameter int NUM_CAND     = 4,
  parameter int CNT_W        = 8,
  parameter int BLINK_CYCLES = 100000000
) (
  input  logic              clock,
  input  logic              reset,
  vote_display_ctrl_if.slave bus
);

  localparam int IDX_W   = $clog2(NUM_CAND);
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_RELOAD = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LEDS_ON      = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    VOTE_IDLE  = 2'd0,
    VOTE_BLINK = 2'd1,
    RESULT     = 2'd2
  } state_t;

  state_t             state_reg;
  logic [BLINK_W-1:0] blink_cnt_reg;
  logic [CNT_W-1:0]   leds_reg;
  logic [IDX_W-1:0]   sel_idx_reg;
  logic               sel_valid_reg;

  // Unpacked view of the candidate counts.
  logic [CNT_W-1:0]   votes [NUM_CAND];

  // Lowest pressed button.
  logic               btn_any;
  logic [IDX_W-1:0]   btn_idx_next;

  // What the display shows in RESULT when nothing is selected.
  logic [CNT_W-1:0]   nosel_leds;
  logic [IDX_W-1:0]   nosel_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CAND; gi++) begin : g_unpack
      assign votes[gi] = bus.cand_votes[gi*CNT_W +: CNT_W];
    end
  endgenerate

  assign btn_any = |bus.cand_button;

  // Priority encoder: scanning downward leaves the lowest set index.
  always_comb begin
    btn_idx_next = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if (bus.cand_button[i]) begin
        btn_idx_next = IDX_W'(i);
      end
    end
  end

`ifdef VOTE_LEADER_DISPLAY_EN
  logic [CNT_W-1:0] leader_val_next;
  logic [IDX_W-1:0] leader_idx_next;
  logic [CNT_W-1:0] leader_val_reg;
  logic [IDX_W-1:0] leader_idx_reg;

  // Max search; strict compare keeps the lowest index on ties.
  always_comb begin
    leader_val_next = votes[0];
    leader_idx_next = '0;
    for (int i = 1; i < NUM_CAND; i++) begin
      if (votes[i] > leader_val_next) begin
        leader_val_next = votes[i];
        leader_idx_next = IDX_W'(i);
      end
    end
  end

  // Register the compare result so the display path sees a short cone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      leader_val_reg <= '0;
      leader_idx_reg <= '0;
    end else begin
      leader_val_reg <= leader_val_next;
      leader_idx_reg <= leader_idx_next;
    end
  end

  assign nosel_leds = leader_val_reg;
  assign nosel_idx  = leader_idx_reg;
`else
  assign nosel_leds = '0;
  assign nosel_idx  = '0;
`endif

  // Main FSM; all outputs are registered and computed from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= VOTE_IDLE;
      blink_cnt_reg <= '0;
      leds_reg      <= '0;
      sel_idx_reg   <= '0;
      sel_valid_reg <= 1'b0;
    end else if (bus.mode) begin
      if (state_reg != RESULT) begin
        // Entering result display: drop any blink and any old selection.
        state_reg     <= RESULT;
        blink_cnt_reg <= '0;
        sel_valid_reg <= 1'b0;
        sel_idx_reg   <= nosel_idx;
        leds_reg      <= nosel_leds;
      end else if (btn_any) begin
        sel_idx_reg   <= btn_idx_next;
        sel_valid_reg <= 1'b1;
        leds_reg      <= votes[btn_idx_next];
      end else if (sel_valid_reg) begin
        leds_reg      <= votes[sel_idx_reg];
      end else begin
        sel_idx_reg   <= nosel_idx;
        leds_reg      <= nosel_leds;
      end
    end else begin
      case (state_reg)
        RESULT: begin
          // Leaving display mode; a vote seen on this edge is ignored.
          state_reg     <= VOTE_IDLE;
          blink_cnt_reg <= '0;
          sel_valid_reg <= 1'b0;
          sel_idx_reg   <= '0;
          leds_reg      <= '0;
        end
        VOTE_IDLE: begin
          if (bus.valid_vote_casted) begin
            state_reg     <= VOTE_BLINK;
            blink_cnt_reg <= BLINK_RELOAD;
            leds_reg      <= LEDS_ON;
          end else begin
            leds_reg      <= '0;
          end
        end
        VOTE_BLINK: begin
          if (bus.valid_vote_casted) begin
            // Retrigger restarts the full blink, even on the terminal cycle.
            blink_cnt_reg <= BLINK_RELOAD;
            leds_reg      <= LEDS_ON;
          end else if (blink_cnt_reg == '0) begin
            state_reg     <= VOTE_IDLE;
            leds_reg      <= '0;
          end else begin
            blink_cnt_reg <= blink_cnt_reg - 1'b1;
            leds_reg      <= LEDS_ON;
          end
        end
        default: begin
          state_reg     <= VOTE_IDLE;
          blink_cnt_reg <= '0;
          sel_valid_reg <= 1'b0;
          sel_idx_reg   <= '0;
          leds_reg      <= '0;
        end
      endcase
    end
  end

  assign bus.LEDs      = leds_reg;
  assign bus.sel_idx   = sel_idx_reg;
  assign bus.sel_valid = sel_valid_reg;

endmodule
